// File: rtl/sgb_lcd_capture.sv
// sgb_lcd_capture
//   Captures the Game Boy LCD pixel stream from the GB core inside the SGB
//   mapper and packs it into SNES 2bpp tile rows. Storage is a ring of four
//   character-row buffers. The SNES CPU reads these buffers byte by byte
//   through the ICD2 register window.
//
// Build option:
//   LCD_CAPTURE_INVERT_EN - when defined, each pixel is stored as 3 - lcd_data,
//                           so GB white (0) becomes SNES colour index 3.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   lcd_ce      pixel strobe, one pixel per asserted cycle
//   lcd_data    GB pixel value 0..3
//   lcd_vs      GB vsync (level); its rising edge restarts the frame
//   buf_sel_wr  pulse: load read buffer select from buf_sel, rewind pointer
//   buf_sel     read buffer index 0..3
//   rd_req      pulse: advance read pointer (wraps after 2*WIDTH-1)
//   rd_data     registered byte at the read pointer
//   row_cnt     character row being written, clamped once past the frame
//   wr_buf      ring buffer being written (row_cnt[1:0])
module sgb_lcd_capture #(
  parameter int LINES = 144,
  parameter int WIDTH = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_ce,
  input  logic [1:0] lcd_data,
  input  logic       lcd_vs,
  input  logic       buf_sel_wr,
  input  logic [1:0] buf_sel,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic [4:0] row_cnt,
  output logic [1:0] wr_buf
);

  localparam int WORDS = 4 * WIDTH;
  localparam int AW    = $clog2(WORDS);
  localparam int PW    = $clog2(2 * WIDTH);

  localparam logic [7:0]    X_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0]    LINE_END = 8'(LINES);
  localparam logic [4:0]    ROW_MAX  = 5'((LINES - 1) / 8);
  localparam logic [PW-1:0] PTR_LAST = PW'(2 * WIDTH - 1);

  logic [7:0]    x;
  logic [7:0]    line;
  logic [7:0]    line_nxt;
  logic [4:0]    row_nxt;
  logic [7:0]    plane0;
  logic [7:0]    plane1;
  logic [7:0]    plane0_nxt;
  logic [7:0]    plane1_nxt;
  logic [1:0]    pix;
  logic          vs_q;
  logic          vs_rise;
  logic          pix_ok;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    rd_buf;
  logic [PW-1:0] rd_ptr;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic [15:0]   mem [WORDS];

  function automatic logic [4:0] row_of(input logic [7:0] l);
    return (l >= LINE_END) ? ROW_MAX : l[7:3];
  endfunction

`ifdef LCD_CAPTURE_INVERT_EN
  assign pix = 2'd3 - lcd_data;
`else
  assign pix = lcd_data;
`endif

  // A vsync edge takes precedence over a pixel arriving in the same cycle.
  assign vs_rise    = lcd_vs & ~vs_q;
  assign pix_ok     = lcd_ce & ~vs_rise & (line < LINE_END);
  assign plane0_nxt = {plane0[6:0], pix[0]};
  assign plane1_nxt = {plane1[6:0], pix[1]};

  // The eighth pixel of a tile row is written together with the shifted-in
  // pixel, so the word is committed in the same cycle it completes.
  assign wr_en   = pix_ok & (x[2:0] == 3'd7);
  assign wr_addr = AW'(line[4:3]) * AW'(WIDTH) + AW'({x[7:3], 3'b000}) + AW'(line[2:0]);
  assign rd_addr = AW'(rd_buf) * AW'(WIDTH) + AW'(rd_ptr[PW-1:1]);

  always_comb begin
    line_nxt = line;
    if (vs_rise) begin
      line_nxt = 8'd0;
    end else if (pix_ok && x == X_LAST) begin
      line_nxt = line + 8'd1;
    end
    row_nxt = row_of(line_nxt);
  end

  // Write side: pixel counters, shift registers, row status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      x       <= 8'd0;
      line    <= 8'd0;
      plane0  <= 8'd0;
      plane1  <= 8'd0;
      row_cnt <= 5'd0;
      wr_buf  <= 2'd0;
    end else begin
      vs_q    <= lcd_vs;
      line    <= line_nxt;
      row_cnt <= row_nxt;
      wr_buf  <= row_nxt[1:0];
      if (vs_rise) begin
        x      <= 8'd0;
        plane0 <= 8'd0;
        plane1 <= 8'd0;
      end else if (pix_ok) begin
        plane0 <= plane0_nxt;
        plane1 <= plane1_nxt;
        x      <= (x == X_LAST) ? 8'd0 : x + 8'd1;
      end
    end
  end

  // Tile RAM write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {plane1_nxt, plane0_nxt};
    end
  end

  // Read side: pointer update, then RAM read one cycle later. rd_data only
  // changes after a pointer update, so it holds steady between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_buf  <= 2'd0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_pend <= buf_sel_wr | rd_req;
      if (buf_sel_wr) begin
        rd_buf <= buf_sel;
        rd_ptr <= '0;
      end else if (rd_req) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (rd_pend) begin
        rd_data <= rd_ptr[0] ? mem[rd_addr][15:8] : mem[rd_addr][7:0];
      end
    end
  end

endmodule

// File: tb/tb_sgb_lcd_capture.sv
module tb_sgb_lcd_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_ce = 1'b0;
  logic [1:0] lcd_data = 2'd0;
  logic       lcd_vs = 1'b0;
  logic       buf_sel_wr = 1'b0;
  logic [1:0] buf_sel = 2'd0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] row_cnt;
  logic [1:0] wr_buf;

  int n_tests = 0;
  int n_fail  = 0;

  sgb_lcd_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_ce     (lcd_ce),
    .lcd_data   (lcd_data),
    .lcd_vs     (lcd_vs),
    .buf_sel_wr (buf_sel_wr),
    .buf_sel    (buf_sel),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .row_cnt    (row_cnt),
    .wr_buf     (wr_buf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         bsel;
    int         ptr;
    logic [1:0] v;
  } vec_t;

  // Stored pixel value for a given GB input value.
  function automatic logic [1:0] stored(input logic [1:0] v);
`ifdef LCD_CAPTURE_INVERT_EN
    return 2'd3 - v;
`else
    return v;
`endif
  endfunction

  // Expected byte of a tile row filled with a single pixel value.
  function automatic logic [7:0] exp_byte(input logic [1:0] v, input bit pl);
    logic [1:0] s;
    s = stored(v);
    return pl ? {8{s[1]}} : {8{s[0]}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [1:0] v);
    lcd_data = v;
    lcd_ce   = 1'b1;
    tick();
    lcd_ce   = 1'b0;
  endtask

  task automatic send_lines(input int n, input logic [1:0] v);
    for (int l = 0; l < n; l++)
      for (int i = 0; i < 160; i++) pix(v);
  endtask

  task automatic vs_pulse();
    lcd_vs = 1'b1;
    tick();
    lcd_vs = 1'b0;
    tick();
    tick();
  endtask

  task automatic step_wait();
    tick();
    tick();
  endtask

  task automatic read_byte(input int bsel, input int ptr, output logic [7:0] val);
    buf_sel    = 2'(bsel);
    buf_sel_wr = 1'b1;
    tick();
    buf_sel_wr = 1'b0;
    for (int i = 0; i < ptr; i++) begin
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
    end
    step_wait();
    val = rd_data;
  endtask

  task automatic check_byte(input string name, input int bsel, input int ptr, input logic [7:0] exp);
    logic [7:0] got;
    read_byte(bsel, ptr, got);
    check(name, {24'd0, got}, {24'd0, exp});
  endtask

  task automatic rd_pulse();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    step_wait();
  endtask

  vec_t vecs [10];
  logic [7:0] pat0, pat1;

  initial begin
    // buffer, byte pointer, pixel value of that tile row
    vecs[0] = '{1, 0,   2'd2};   // line 8 tile 0
    vecs[1] = '{1, 1,   2'd2};
    vecs[2] = '{0, 14,  2'd2};   // line 7 tile 0
    vecs[3] = '{0, 15,  2'd2};
    vecs[4] = '{0, 319, 2'd2};   // line 7 tile 19
    vecs[5] = '{1, 305, 2'd2};   // line 8 tile 19
    vecs[6] = '{1, 2,   2'd0};   // line 9 tile 0
    vecs[7] = '{2, 0,   2'd1};   // line 16 tile 0
    vecs[8] = '{2, 3,   2'd3};   // line 17 tile 0
    vecs[9] = '{2, 15,  2'd3};   // line 23 tile 0

`ifdef LCD_CAPTURE_INVERT_EN
    pat0 = 8'hAA;
    pat1 = 8'hCC;
`else
    pat0 = 8'h55;
    pat1 = 8'h33;
`endif

    // Reset state
    repeat (3) tick();
    check("reset rd_data", {24'd0, rd_data}, 32'h00);
    check("reset row_cnt", {27'd0, row_cnt}, 32'd0);
    check("reset wr_buf",  {30'd0, wr_buf},  32'd0);
    rst_n = 1'b1;
    tick();

    // Eight pixels of value 1 on line 0
    vs_pulse();
    for (int i = 0; i < 8; i++) pix(2'd1);
    check_byte("p1 byte0", 0, 0, exp_byte(2'd1, 1'b0));
    check_byte("p1 byte1", 0, 1, exp_byte(2'd1, 1'b1));
    check("p1 row_cnt", {27'd0, row_cnt}, 32'd0);
    check("p1 wr_buf",  {30'd0, wr_buf},  32'd0);

    // Repeating 0,1,2,3 pattern on lines 0 and 1
    vs_pulse();
    for (int i = 0; i < 320; i++) pix(2'(i % 4));
    check_byte("pat byte0",   0, 0,   pat0);
    check_byte("pat byte1",   0, 1,   pat1);
    check_byte("pat byte2",   0, 2,   pat0);
    check_byte("pat byte3",   0, 3,   pat1);
    check_byte("pat byte304", 0, 304, pat0);
    check_byte("pat byte305", 0, 305, pat1);

    // Nine lines of value 2, then lines 9..23 with distinct values
    vs_pulse();
    send_lines(9, 2'd2);
    check("9 lines row_cnt", {27'd0, row_cnt}, 32'd1);
    check("9 lines wr_buf",  {30'd0, wr_buf},  32'd1);
    send_lines(7, 2'd0);
    send_lines(1, 2'd1);
    send_lines(7, 2'd3);
    check("24 lines row_cnt", {27'd0, row_cnt}, 32'd3);
    check("24 lines wr_buf",  {30'd0, wr_buf},  32'd3);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] got;
      read_byte(vecs[i].bsel, vecs[i].ptr, got);
      check($sformatf("vec%0d b%0d p%0d", i, vecs[i].bsel, vecs[i].ptr),
            {24'd0, got}, {24'd0, exp_byte(vecs[i].v, vecs[i].ptr[0])});
    end

    // Read pointer wrap 319 -> 0
    check_byte("wrap ptr319", 0, 319, exp_byte(2'd2, 1'b1));
    rd_pulse();
    check("wrap ptr0", {24'd0, rd_data}, {24'd0, exp_byte(2'd2, 1'b0)});

    // buf_sel_wr and rd_req together: select wins, pointer rewinds
    check_byte("sim pre", 0, 0, exp_byte(2'd2, 1'b0));
    buf_sel    = 2'd2;
    buf_sel_wr = 1'b1;
    rd_req     = 1'b1;
    tick();
    buf_sel_wr = 1'b0;
    rd_req     = 1'b0;
    step_wait();
    check("sim ptr0", {24'd0, rd_data}, {24'd0, exp_byte(2'd1, 1'b0)});
    rd_pulse();
    check("sim ptr1", {24'd0, rd_data}, {24'd0, exp_byte(2'd1, 1'b1)});
    rd_pulse();
    check("sim ptr2", {24'd0, rd_data}, {24'd0, exp_byte(2'd3, 1'b0)});
    rd_pulse();
    check("sim ptr3", {24'd0, rd_data}, {24'd0, exp_byte(2'd3, 1'b1)});

    // Vsync in the middle of line 3
    vs_pulse();
    check("vs row_cnt", {27'd0, row_cnt}, 32'd0);
    send_lines(3, 2'd0);
    for (int i = 0; i < 5; i++) pix(2'd3);
    vs_pulse();
    check("midvs row_cnt", {27'd0, row_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) pix(2'd1);
    check_byte("midvs line0 b0", 0, 0, exp_byte(2'd1, 1'b0));
    check_byte("midvs line0 b1", 0, 1, exp_byte(2'd1, 1'b1));
    check_byte("midvs line1 b2", 0, 2, exp_byte(2'd0, 1'b0));
    check_byte("midvs line3 b6", 0, 6, exp_byte(2'd2, 1'b0));
    check_byte("midvs line3 b7", 0, 7, exp_byte(2'd2, 1'b1));

    // Pixel in the same cycle as the vsync edge is dropped
    lcd_vs   = 1'b1;
    lcd_data = 2'd3;
    lcd_ce   = 1'b1;
    tick();
    lcd_ce   = 1'b0;
    for (int i = 0; i < 8; i++) pix(2'd2);
    lcd_vs = 1'b0;
    tick();
    check_byte("vs+ce b0", 0, 0, exp_byte(2'd2, 1'b0));
    check_byte("vs+ce b1", 0, 1, exp_byte(2'd2, 1'b1));

    // 150 lines: lines past the frame neither move row_cnt nor touch RAM
    vs_pulse();
    send_lines(144, 2'd1);
    send_lines(6, 2'd2);
    check("ovf row_cnt", {27'd0, row_cnt}, 32'd17);
    check("ovf wr_buf",  {30'd0, wr_buf},  32'd1);
    check_byte("ovf b2 byte0",  2, 0,  exp_byte(2'd1, 1'b0));
    check_byte("ovf b2 byte1",  2, 1,  exp_byte(2'd1, 1'b1));
    check_byte("ovf b2 byte11", 2, 11, exp_byte(2'd1, 1'b1));

    // Asynchronous reset mid-line, mid-cycle
    check_byte("prerst", 2, 0, exp_byte(2'd1, 1'b0));
    for (int i = 0; i < 3; i++) pix(2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rd_data", {24'd0, rd_data}, 32'h00);
    check("async row_cnt", {27'd0, row_cnt}, 32'd0);
    check("async wr_buf",  {30'd0, wr_buf},  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
